// File: rtl/mem_arbiter_pkg.sv
// Shared types for the L1 <-> memory port arbiter.
//   Data / DataWAddr : 32-bit data word and 30-bit word address.
//   MEM_LINE_WORDS   : cache-line length in words, shared by caches and arbiter.
//   MemOwner         : requester currently owning the memory port.
//   MemArbState      : arbiter sequencer state.
package mem_arbiter_pkg;

  typedef logic [31:0] Data;
  typedef logic [29:0] DataWAddr;

  localparam int unsigned MEM_LINE_WORDS = 4;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } MemOwner;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } MemArbState;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker.
//   i_clock, i_reset   : clock, asynchronous active-low reset
//   i_en               : a pick made while enabled updates the last-granted pointer
//   i_inst_req         : instruction-side request
//   i_data_req         : data-side request
//   o_valid            : at least one request pending
//   o_owner            : side picked this cycle (combinational)
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic    i_clock,
  input  logic    i_reset,
  input  logic    i_en,
  input  logic    i_inst_req,
  input  logic    i_data_req,
  output logic    o_valid,
  output MemOwner o_owner
);

  MemOwner r_lg;

  // On a conflict the side that did not win last time goes first; reset
  // value INST means data wins the first conflict.
  always_comb begin
    o_valid = i_inst_req | i_data_req;
    if (i_inst_req && i_data_req) begin
      o_owner = (r_lg == INST) ? DATA : INST;
    end else begin
      o_owner = i_data_req ? DATA : INST;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_lg <= INST;
    end else if (i_en && o_valid) begin
      r_lg <= o_owner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and burst sequencer for the single memory port behind the L1s.
// Grants instruction / data requesters round-robin, then runs the grant as
// one word or a LINE_WORDS-beat critical-word-first burst wrapping inside
// the line. Read data, write-beat acceptance and completion are returned
// to the owning requester.
//   i_clock, i_reset          : clock, asynchronous active-low reset
//   i_inst_*                  : instruction requester (read only)
//   o_inst_*                  : grant, read data/valid, done pulse
//   i_data_*                  : data requester (read or write)
//   o_data_*                  : grant, read data/valid, done, write-beat accept
//   o_mem_* / i_mem_*         : memory port
//   o_busy                    : a transfer is in progress
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = MEM_LINE_WORDS
) (
  input  logic        i_clock,
  input  logic        i_reset,

  input  logic        i_inst_req,
  input  logic        i_inst_burst,
  input  logic [29:0] i_inst_addr,
  output logic        o_inst_gnt,
  output logic        o_inst_rvalid,
  output logic [31:0] o_inst_rdata,
  output logic        o_inst_done,

  input  logic        i_data_req,
  input  logic        i_data_burst,
  input  logic [29:0] i_data_addr,
  input  logic        i_data_we,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_gnt,
  output logic        o_data_rvalid,
  output logic [31:0] o_data_rdata,
  output logic        o_data_done,
  output logic        o_data_wnext,

  output logic [29:0] o_mem_addr,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,

  output logic        o_busy
);

  localparam int unsigned AW   = $bits(DataWAddr);
  localparam int unsigned IDXW = $clog2(LINE_WORDS);
  localparam logic [IDXW-1:0] LAST_CNT = IDXW'(LINE_WORDS - 1);

  MemArbState         r_state;
  MemOwner            r_owner;
  logic [AW-IDXW-1:0] r_line;
  logic [IDXW-1:0]    r_idx;
  logic [IDXW-1:0]    r_cnt;
  logic               r_we;
  logic               r_burst;
  logic               r_inst_gnt;
  logic               r_data_gnt;
  logic               r_mem_we;
  logic               r_mem_re;

  logic               w_pick_valid;
  MemOwner            w_pick;
  logic [AW-1:0]      w_req_addr;
  logic               w_req_we;
  logic               w_req_burst;
  logic               w_beat;
  logic               w_last;
  logic               w_xfer;

  assign w_xfer = (r_state == XFER);

  mem_arb_rr u_rr (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_en       (!w_xfer),
    .i_inst_req (i_inst_req),
    .i_data_req (i_data_req),
    .o_valid    (w_pick_valid),
    .o_owner    (w_pick)
  );

  // Instruction side never writes.
  always_comb begin
    w_req_addr  = (w_pick == DATA) ? i_data_addr  : i_inst_addr;
    w_req_burst = (w_pick == DATA) ? i_data_burst : i_inst_burst;
    w_req_we    = (w_pick == DATA) && i_data_we;
  end

  assign w_beat = w_xfer && i_mem_ready;
  assign w_last = !r_burst || (r_cnt == LAST_CNT);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_owner    <= INST;
      r_line     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_burst    <= 1'b0;
      r_inst_gnt <= 1'b0;
      r_data_gnt <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state    <= XFER;
            r_owner    <= w_pick;
            r_line     <= w_req_addr[AW-1:IDXW];
            r_idx      <= w_req_addr[IDXW-1:0];
            r_cnt      <= '0;
            r_we       <= w_req_we;
            r_burst    <= w_req_burst;
            r_inst_gnt <= (w_pick == INST);
            r_data_gnt <= (w_pick == DATA);
            r_mem_we   <= w_req_we;
            r_mem_re   <= !w_req_we;
          end
        end
        XFER: begin
          if (i_mem_ready) begin
            // idx is exactly IDXW bits wide, so the increment wraps in the line.
            r_idx <= r_idx + IDXW'(1);
            r_cnt <= r_cnt + IDXW'(1);
            if (w_last) begin
              r_state    <= IDLE;
              r_inst_gnt <= 1'b0;
              r_data_gnt <= 1'b0;
              r_mem_we   <= 1'b0;
              r_mem_re   <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port-facing outputs are gated by the registered state so that every
  // output is zero while reset is held, including the pass-through paths.
  always_comb begin
    o_busy        = w_xfer;
    o_inst_gnt    = r_inst_gnt;
    o_data_gnt    = r_data_gnt;
    o_mem_we      = r_mem_we;
    o_mem_re      = r_mem_re;
    o_mem_addr    = w_xfer ? {r_line, r_idx} : '0;
    o_mem_wdata   = r_mem_we ? i_data_wdata : '0;

    o_inst_rvalid = w_beat && (r_owner == INST) && !r_we;
    o_data_rvalid = w_beat && (r_owner == DATA) && !r_we;
    o_inst_rdata  = o_inst_rvalid ? i_mem_rdata : '0;
    o_data_rdata  = o_data_rvalid ? i_mem_rdata : '0;
    o_data_wnext  = w_beat && r_we;

    o_inst_done   = w_beat && w_last && (r_owner == INST);
    o_data_done   = w_beat && w_last && (r_owner == DATA);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req, inst_burst;
  logic [29:0] inst_addr;
  logic        inst_gnt, inst_rvalid, inst_done;
  logic [31:0] inst_rdata;
  logic        data_req, data_burst, data_we;
  logic [29:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt, data_rvalid, data_done, data_wnext;
  logic [31:0] data_rdata;
  logic [29:0] mem_addr;
  logic        mem_we, mem_re;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WORDS(L)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_inst_req    (inst_req),
    .i_inst_burst  (inst_burst),
    .i_inst_addr   (inst_addr),
    .o_inst_gnt    (inst_gnt),
    .o_inst_rvalid (inst_rvalid),
    .o_inst_rdata  (inst_rdata),
    .o_inst_done   (inst_done),
    .i_data_req    (data_req),
    .i_data_burst  (data_burst),
    .i_data_addr   (data_addr),
    .i_data_we     (data_we),
    .i_data_wdata  (data_wdata),
    .o_data_gnt    (data_gnt),
    .o_data_rvalid (data_rvalid),
    .o_data_rdata  (data_rdata),
    .o_data_done   (data_done),
    .o_data_wnext  (data_wnext),
    .o_mem_addr    (mem_addr),
    .o_mem_we      (mem_we),
    .o_mem_re      (mem_re),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ready   (mem_ready),
    .o_busy        (busy)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one active transfer described by owner,
  // start address, beats completed and beats required.
  bit          m_busy;
  int unsigned m_owner;   // 0 = inst, 1 = data
  int unsigned m_lg;      // last granted side
  int unsigned m_start;
  int unsigned m_k;
  int unsigned m_n;
  bit          m_we;
  bit          m_done_i, m_done_d;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_lg = 0; m_k = 0; m_n = 1; m_we = 0; m_start = 0;
    m_done_i = 0; m_done_d = 0;
  endtask

  function automatic logic [29:0] exp_addr();
    int unsigned base_line = m_start - (m_start % L);
    return 30'(base_line + ((m_start % L) + m_k) % L);
  endfunction

  task automatic check_cycle();
    bit beat;
    bit last;
    beat = m_busy && mem_ready;
    last = beat && (m_k + 1 == m_n);
    check_eq("busy",        32'(busy),        32'(m_busy));
    check_eq("inst_gnt",    32'(inst_gnt),    32'(m_busy && m_owner == 0));
    check_eq("data_gnt",    32'(data_gnt),    32'(m_busy && m_owner == 1));
    check_eq("mem_addr",    32'(mem_addr),    m_busy ? 32'(exp_addr()) : 32'd0);
    check_eq("mem_re",      32'(mem_re),      32'(m_busy && !m_we));
    check_eq("mem_we",      32'(mem_we),      32'(m_busy && m_we));
    check_eq("mem_wdata",   mem_wdata,        (m_busy && m_we) ? data_wdata : 32'd0);
    check_eq("inst_rvalid", 32'(inst_rvalid), 32'(beat && m_owner == 0));
    check_eq("inst_rdata",  inst_rdata,       (beat && m_owner == 0) ? mem_rdata : 32'd0);
    check_eq("data_rvalid", 32'(data_rvalid), 32'(beat && m_owner == 1 && !m_we));
    check_eq("data_rdata",  data_rdata,       (beat && m_owner == 1 && !m_we) ? mem_rdata : 32'd0);
    check_eq("data_wnext",  32'(data_wnext),  32'(beat && m_we));
    check_eq("inst_done",   32'(inst_done),   32'(last && m_owner == 0));
    check_eq("data_done",   32'(data_done),   32'(last && m_owner == 1));
  endtask

  // Decide what happens at the coming rising edge from the present inputs.
  task automatic model_advance();
    if (m_busy) begin
      if (mem_ready) begin
        m_k++;
        if (m_k == m_n) begin
          m_busy = 0;
          if (m_owner == 0) m_done_i = 1; else m_done_d = 1;
        end
      end
    end else if (inst_req || data_req) begin
      if (inst_req && data_req) m_owner = (m_lg == 0) ? 1 : 0;
      else                      m_owner = data_req ? 1 : 0;
      m_lg    = m_owner;
      m_busy  = 1;
      m_k     = 0;
      m_start = (m_owner == 1) ? int'(data_addr) : int'(inst_addr);
      m_n     = ((m_owner == 1) ? data_burst : inst_burst) ? L : 1;
      m_we    = (m_owner == 1) && data_we;
    end
  endtask

  task automatic finish_cycle();
    check_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic rand_inputs();
    if (m_done_i) begin inst_req = 0; m_done_i = 0; end
    if (m_done_d) begin data_req = 0; m_done_d = 0; end
    if (!inst_req && $urandom_range(0, 2) == 0) begin
      inst_req   = 1;
      inst_burst = 1'($urandom);
      inst_addr  = 30'($urandom);
    end
    if (!data_req && $urandom_range(0, 2) == 0) begin
      data_req   = 1;
      data_burst = 1'($urandom);
      data_we    = 1'($urandom);
      data_addr  = 30'($urandom);
    end
    // Disturb the owner's request fields mid-transfer; they must be ignored.
    if (m_busy && $urandom_range(0, 3) == 0) begin
      if (m_owner == 0) begin
        inst_addr  = 30'($urandom);
        inst_burst = 1'($urandom);
      end else begin
        data_addr  = 30'($urandom);
        data_burst = 1'($urandom);
        data_we    = 1'($urandom);
      end
    end
    mem_ready  = ($urandom_range(0, 2) != 0);
    mem_rdata  = $urandom;
    data_wdata = $urandom;
  endtask

  logic [29:0] wrap_exp [4];
  int unsigned beats;
  int unsigned busy_cycles;
  bit          seen_done;

  initial begin
    wrap_exp[0] = 30'h1A; wrap_exp[1] = 30'h1B; wrap_exp[2] = 30'h18; wrap_exp[3] = 30'h19;

    rst_n = 0;
    inst_req = 0; inst_burst = 0; inst_addr = '0;
    data_req = 0; data_burst = 0; data_addr = '0; data_we = 0; data_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    rst_n = 1;
    step();

    // Single data read, ready on the second XFER cycle
    data_req = 1; data_burst = 0; data_we = 0; data_addr = 30'h40;
    busy_cycles = 0;
    step();
    mem_ready = 0;
    @(negedge clk); if (busy) busy_cycles++; finish_cycle();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    if (busy) busy_cycles++;
    check_eq("sr_rvalid", 32'(data_rvalid), 32'd1);
    check_eq("sr_rdata",  data_rdata,       32'hDEADBEEF);
    check_eq("sr_done",   32'(data_done),   32'd1);
    finish_cycle();
    data_req = 0; m_done_d = 0; mem_ready = 0;
    @(negedge clk); if (busy) busy_cycles++; finish_cycle();
    check_eq("sr_busy_cycles", busy_cycles, 32'd2);

    // Wrapping instruction burst, ready every cycle
    inst_req = 1; inst_burst = 1; inst_addr = 30'h1A; mem_ready = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'h1000 + 32'(i);
      @(negedge clk);
      check_eq("wrap_addr",   32'(mem_addr),    32'(wrap_exp[i]));
      check_eq("wrap_rvalid", 32'(inst_rvalid), 32'd1);
      check_eq("wrap_done",   32'(inst_done),   32'(i == 3));
      finish_cycle();
    end
    inst_req = 0; m_done_i = 0;
    step();

    // Conflict out of reset: DATA, INST, DATA, INST with an idle cycle between
    rst_n = 0; #2; rst_n = 1;
    model_reset();
    inst_req = 1; inst_burst = 0; inst_addr = 30'h100;
    data_req = 1; data_burst = 0; data_we = 0; data_addr = 30'h200;
    mem_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) check_eq("conf_idle", 32'({inst_gnt, data_gnt}), 32'd0);
      else            check_eq("conf_gnt",  32'({inst_gnt, data_gnt}), ((c / 2) % 2 == 0) ? 32'd1 : 32'd2);
      finish_cycle();
    end
    inst_req = 0; data_req = 0; m_done_i = 0; m_done_d = 0;
    step();

    // Write burst with alternating ready; wdata advances on wnext
    data_req = 1; data_burst = 1; data_we = 1; data_addr = 30'h20; data_wdata = 32'hA0;
    mem_ready = 0;
    step();
    beats = 0; seen_done = 0;
    for (int c = 0; c < 16 && !seen_done; c++) begin
      mem_ready = 1'(c % 2);
      @(negedge clk);
      check_eq("wb_re",    32'(mem_re),   32'd0);
      check_eq("wb_we",    32'(mem_we),   32'd1);
      check_eq("wb_addr",  32'(mem_addr), 32'h20 + beats);
      check_eq("wb_wdata", mem_wdata,     32'hA0 + beats);
      if (data_wnext) beats++;
      if (data_done) seen_done = 1;
      finish_cycle();
      data_wdata = 32'hA0 + beats;
    end
    check_eq("wb_beats", beats, 32'd4);
    check_eq("wb_done",  32'(seen_done), 32'd1);
    data_req = 0; data_we = 0; m_done_d = 0; mem_ready = 0;
    step();

    // Reset in the middle of an instruction burst
    inst_req = 1; inst_burst = 1; inst_addr = 30'h05; mem_ready = 1;
    step();
    step();
    data_req = 1; data_burst = 0; data_we = 0; data_addr = 30'h77;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_cycle();
    @(posedge clk);
    #1;
    rst_n = 1;
    step();
    @(negedge clk);
    check_eq("rst_first_gnt", 32'({inst_gnt, data_gnt}), 32'd1);
    finish_cycle();

    // Drain, then pulse ready in IDLE with no requests
    inst_req = 0; data_req = 0;
    for (int c = 0; c < 40 && m_busy; c++) step();
    m_done_i = 0; m_done_d = 0;
    check_eq("drain_idle", 32'(m_busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1;
      step();
    end
    check_eq("idle_ready_busy", 32'(busy), 32'd0);

    // Randomised traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
